switch_out_arbiter: RTL and testbench

SWITCH_OUT_ARBITER -- requirements
Module: switch_out_arbiter

---
 rtl/switch_out_arbiter.sv | 123 ++++++++++++
 tb/tb_switch_out_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_out_arbiter.sv
// Output-port arbiter for a small crossbar switch.
// NUM_SRC input FIFOs compete for one output register. A round-robin pointer
// picks one requester whenever the output slot is free: either the register
// is empty, or its packet is leaving this cycle. The winner gets a one-cycle
// grant_ack and its data lands in the output register on the next edge.
// A saturating counter tracks how many packets downstream has accepted.
module switch_out_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 16,
  localparam int SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        req_valid,
  input  logic [NUM_SRC*DATA_W-1:0] req_data,
  output logic [NUM_SRC-1:0]        grant_ack,
  output logic                      valid_out,
  output logic [DATA_W-1:0]         data_out,
  output logic [SRC_W-1:0]          src_out,
  input  logic                      out_ready,
  output logic [CNT_W-1:0]          pkt_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             state;
  logic [SRC_W-1:0]   last_grant;

  logic               drain;
  logic               slot_free;
  logic               found;
  logic [SRC_W-1:0]   grant_idx;
  logic [SRC_W-1:0]   cand;
  logic               do_grant;
  logic [DATA_W-1:0]  sel_data;

  // A packet leaves when the register holds one and downstream is ready; that
  // same cycle the register can be refilled, which gives one packet per cycle.
  assign drain     = valid_out && out_ready;
  assign slot_free = (state == EMPTY) || drain;
  assign do_grant  = slot_free && found && !rst;

  // Round-robin search: start one past the last winner and wrap, so every
  // continuously requesting source is served within NUM_SRC grants.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = SRC_W'((int'(last_grant) + k) % NUM_SRC);
      if (!found && req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Select the winner's data and raise its one-hot acknowledge in the grant cycle.
  always_comb begin
    sel_data  = '0;
    grant_ack = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_idx == SRC_W'(i)) begin
        sel_data     = req_data[i*DATA_W +: DATA_W];
        grant_ack[i] = do_grant;
      end
    end
  end

  // Output register FSM: capture on grant, empty out on a drain with nothing to
  // replace it, and hold everything steady while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      valid_out  <= 1'b0;
      data_out   <= '0;
      src_out    <= '0;
      last_grant <= SRC_W'(NUM_SRC - 1);
    end else begin
      case (state)
        EMPTY: begin
          if (do_grant) begin
            state      <= FULL;
            valid_out  <= 1'b1;
            data_out   <= sel_data;
            src_out    <= grant_idx;
            last_grant <= grant_idx;
          end
        end
        FULL: begin
          if (do_grant) begin
            state      <= FULL;
            valid_out  <= 1'b1;
            data_out   <= sel_data;
            src_out    <= grant_idx;
            last_grant <= grant_idx;
          end else if (drain) begin
            state     <= EMPTY;
            valid_out <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          valid_out <= 1'b0;
        end
      endcase
    end
  end

  // Count delivered packets, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_count <= '0;
    end else if (drain && (pkt_count != {CNT_W{1'b1}})) begin
      pkt_count <= pkt_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_switch_out_arbiter.sv
// Self-checking bench for switch_out_arbiter.
// A behavioural model (rotating priority pointer, one-entry output slot,
// saturating delivery count) predicts every output each cycle, and directed
// scenarios pin the model with hand-computed sequences. The DUT is built
// with a 4-bit counter so saturation is reachable in a short run.
module tb_switch_out_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int SW = 2;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    grant_ack;
  logic            valid_out;
  logic [DW-1:0]   data_out;
  logic [SW-1:0]   src_out;
  logic            out_ready;
  logic [CW-1:0]   pkt_count;

  int n_checks = 0;
  int n_errors = 0;

  int            m_next;
  bit            m_valid;
  logic [DW-1:0] m_data;
  int            m_src;
  int            m_count;

  int            grant_log[$];
  logic [DW-1:0] accept_log[$];

  switch_out_arbiter #(
    .NUM_SRC(N),
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_data (req_data),
    .grant_ack(grant_ack),
    .valid_out(valid_out),
    .data_out (data_out),
    .src_out  (src_out),
    .out_ready(out_ready),
    .pkt_count(pkt_count)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: bump the counters and report any difference.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Drive all request-side inputs at once.
  task automatic applyStimulus(input logic [N-1:0] rv, input logic [N*DW-1:0] rd,
                               input logic rdy);
    req_valid = rv;
    req_data  = rd;
    out_ready = rdy;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearLogs();
    grant_log.delete();
    accept_log.delete();
  endtask

  // Hold reset for two cycles with new stimulus in place, release after an edge.
  task automatic resetWith(input logic [N-1:0] rv, input logic [N*DW-1:0] rd,
                           input logic rdy);
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(rv, rd, rdy);
    clearLogs();
    waitCycles(2);
    rst = 1'b0;
  endtask

  function automatic int countInt(input int v);
    int c;
    c = 0;
    foreach (grant_log[k]) if (grant_log[k] == v) c++;
    return c;
  endfunction

  function automatic int countData(input logic [DW-1:0] v);
    int c;
    c = 0;
    foreach (accept_log[k]) if (accept_log[k] == v) c++;
    return c;
  endfunction

  function automatic int grantAt(input int k);
    return (k < grant_log.size()) ? grant_log[k] : -1;
  endfunction

  function automatic logic [31:0] acceptAt(input int k);
    return (k < accept_log.size()) ? 32'(accept_log[k]) : 32'hFFFF_FFFF;
  endfunction

  // Reference model and per-cycle compare. Inputs are steady at the falling
  // edge, so the model predicts this cycle's grant and then steps to the state
  // the DUT must hold after the next rising edge. DUT grants and accepted
  // packets are logged for the directed checks.
  always @(negedge clk) begin
    int            eg;
    int            s;
    bit            free;
    logic [N-1:0]  exp_ack;
    if (rst) begin
      checkOutput("rst_valid_out", 32'(valid_out), 32'd0);
      checkOutput("rst_grant_ack", 32'(grant_ack), 32'd0);
      checkOutput("rst_pkt_count", 32'(pkt_count), 32'd0);
      checkOutput("rst_data_out", 32'(data_out), 32'd0);
      checkOutput("rst_src_out", 32'(src_out), 32'd0);
      m_valid = 1'b0;
      m_next  = 0;
      m_count = 0;
      m_src   = 0;
      m_data  = '0;
    end else begin
      free = !m_valid || out_ready;
      eg   = -1;
      if (free) begin
        for (int k = 0; k < N; k++) begin
          s = (m_next + k) % N;
          if (eg < 0 && req_valid[s]) eg = s;
        end
      end
      exp_ack = (eg >= 0) ? N'(1 << eg) : '0;
      checkOutput("model_grant_ack", 32'(grant_ack), 32'(exp_ack));
      checkOutput("model_valid_out", 32'(valid_out), 32'(m_valid));
      checkOutput("model_pkt_count", 32'(pkt_count), 32'(m_count));
      if (m_valid) begin
        checkOutput("model_data_out", 32'(data_out), 32'(m_data));
        checkOutput("model_src_out", 32'(src_out), 32'(m_src));
      end
      for (int i = 0; i < N; i++) if (grant_ack[i]) grant_log.push_back(i);
      if (valid_out && out_ready) accept_log.push_back(data_out);
      if (m_valid && out_ready && m_count < (1 << CW) - 1) m_count++;
      if (eg >= 0) begin
        m_valid = 1'b1;
        m_data  = req_data[eg*DW +: DW];
        m_src   = eg;
        m_next  = (eg + 1) % N;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Directed scenarios with hand-computed expectations.
  initial begin
    int exp_g[5];
    logic [7:0] exp_d[5];
    exp_g = '{0, 1, 2, 3, 0};
    exp_d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};

    rst = 1'b1;
    applyStimulus('0, '0, 1'b0);
    waitCycles(2);
    @(negedge clk);
    #1;
    checkOutput("reset_valid_out", 32'(valid_out), 32'd0);
    checkOutput("reset_grant_ack", 32'(grant_ack), 32'd0);
    checkOutput("reset_pkt_count", 32'(pkt_count), 32'd0);

    // All four sources streaming with downstream always ready.
    $display("[TB] round-robin streaming");
    resetWith(4'hF, {8'hA3, 8'hA2, 8'hA1, 8'hA0}, 1'b1);
    waitCycles(8);
    applyStimulus('0, {8'hA3, 8'hA2, 8'hA1, 8'hA0}, 1'b1);
    waitCycles(2);
    @(negedge clk);
    #1;
    checkOutput("rr_grant_count", 32'(grant_log.size()), 32'd8);
    for (int k = 0; k < 5; k++) begin
      checkOutput("rr_grant_seq", 32'(grantAt(k)), 32'(exp_g[k]));
      checkOutput("rr_data_seq", acceptAt(k), 32'(exp_d[k]));
    end
    checkOutput("rr_pkt_count", 32'(pkt_count), 32'd8);

    // Single source held in the register by a five-cycle stall.
    $display("[TB] stall hold");
    resetWith(4'b0100, {8'h00, 8'h5C, 8'h00, 8'h00}, 1'b0);
    waitCycles(1);
    applyStimulus('0, {8'h00, 8'h5C, 8'h00, 8'h00}, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      checkOutput("stall_valid_out", 32'(valid_out), 32'd1);
      checkOutput("stall_data_out", 32'(data_out), 32'h5C);
      checkOutput("stall_src_out", 32'(src_out), 32'd2);
      checkOutput("stall_grant_ack", 32'(grant_ack), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    waitCycles(2);
    @(negedge clk);
    #1;
    checkOutput("stall_ack_pulses", 32'(countInt(2)), 32'd1);
    checkOutput("stall_grant_total", 32'(grant_log.size()), 32'd1);
    checkOutput("stall_delivered", acceptAt(0), 32'h5C);
    checkOutput("stall_pkt_count", 32'(pkt_count), 32'd1);
    checkOutput("stall_drained", 32'(valid_out), 32'd0);

    // Wrap from source 3 to source 0, then onward to 3.
    $display("[TB] wrap ordering");
    resetWith(4'b1001, {8'h33, 8'h00, 8'h00, 8'h30}, 1'b1);
    waitCycles(2);
    applyStimulus('0, {8'h33, 8'h00, 8'h00, 8'h30}, 1'b1);
    waitCycles(2);
    @(negedge clk);
    #1;
    checkOutput("wrap_first", 32'(grantAt(0)), 32'd0);
    checkOutput("wrap_second", 32'(grantAt(1)), 32'd3);
    checkOutput("wrap_data", acceptAt(1), 32'h33);

    // Reset while a packet sits in the stalled register.
    $display("[TB] reset mid-packet");
    waitCycles(1);
    applyStimulus(4'b0010, {8'h00, 8'h00, 8'h77, 8'h00}, 1'b0);
    waitCycles(1);
    applyStimulus('0, {8'h00, 8'h00, 8'h77, 8'h00}, 1'b0);
    waitCycles(1);
    @(negedge clk);
    #1;
    checkOutput("held_data_out", 32'(data_out), 32'h77);
    @(posedge clk);
    #1;
    rst = 1'b1;
    clearLogs();
    @(negedge clk);
    #1;
    checkOutput("midrst_valid_out", 32'(valid_out), 32'd0);
    checkOutput("midrst_pkt_count", 32'(pkt_count), 32'd0);
    applyStimulus(4'b1010, {8'h33, 8'h00, 8'h11, 8'h00}, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    waitCycles(1);
    applyStimulus(4'b1000, {8'h33, 8'h00, 8'h11, 8'h00}, 1'b1);
    waitCycles(1);
    applyStimulus('0, {8'h33, 8'h00, 8'h11, 8'h00}, 1'b1);
    waitCycles(2);
    @(negedge clk);
    #1;
    checkOutput("midrst_first_grant", 32'(grantAt(0)), 32'd1);
    checkOutput("midrst_no_77", 32'(countData(8'h77)), 32'd0);
    checkOutput("midrst_first_data", acceptAt(0), 32'h11);

    // A source asks while the slot is blocked, then gives up.
    $display("[TB] withdrawn request");
    waitCycles(1);
    applyStimulus(4'b0001, {8'h00, 8'h00, 8'h00, 8'h10}, 1'b0);
    clearLogs();
    waitCycles(1);
    applyStimulus(4'b0100, {8'h00, 8'hEE, 8'h00, 8'h10}, 1'b0);
    waitCycles(3);
    applyStimulus(4'b0000, {8'h00, 8'hEE, 8'h00, 8'h10}, 1'b0);
    waitCycles(1);
    applyStimulus(4'b0010, {8'h00, 8'hEE, 8'h21, 8'h10}, 1'b1);
    waitCycles(1);
    applyStimulus(4'b0000, {8'h00, 8'hEE, 8'h21, 8'h10}, 1'b1);
    waitCycles(2);
    @(negedge clk);
    #1;
    checkOutput("withdraw_no_ack", 32'(countInt(2)), 32'd0);
    checkOutput("withdraw_no_data", 32'(countData(8'hEE)), 32'd0);
    checkOutput("withdraw_seq0", acceptAt(0), 32'h10);
    checkOutput("withdraw_seq1", acceptAt(1), 32'h21);

    // Drive far past the 4-bit counter limit.
    $display("[TB] counter saturation");
    resetWith(4'b0001, {8'h00, 8'h00, 8'h00, 8'h5A}, 1'b1);
    waitCycles(22);
    applyStimulus('0, {8'h00, 8'h00, 8'h00, 8'h5A}, 1'b1);
    waitCycles(2);
    @(negedge clk);
    #1;
    checkOutput("sat_deliveries", 32'(accept_log.size()), 32'd22);
    checkOutput("sat_pkt_count", 32'(pkt_count), 32'd15);
    waitCycles(3);
    @(negedge clk);
    #1;
    checkOutput("sat_pkt_count_hold", 32'(pkt_count), 32'd15);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
